// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences the iCE40 96 MHz PLL from the 12 MHz reference: reset, lock qualification,
//          system reset release, lock-loss recovery with bounded retries, fault reporting.
// Latency: pll_locked reaches the FSM through a 2-FF synchronizer; all outputs are registered
//          and change on the same edge as the state. No backpressure: relock_req is a single-cycle pulse.
//
// Ports:
//   clock_in        12 MHz reference clock, the only clock
//   reset_n         asynchronous active-low reset
//   pll_locked      PLL LOCK output, asynchronous to clock_in
//   relock_req      single-cycle request to re-sequence the PLL
//   pll_resetb      PLL RESETB (active-low)
//   sys_reset_n     system reset (active-low), high only in RUN
//   running         high in RUN
//   fault           high in FAULT
//   retry_count     retries used in the current acquisition
//   lock_loss_count lock losses seen in RUN, saturating at 255
module pll_lock_supervisor #(
  parameter int RESET_CYCLES  = 12,
  parameter int LOCK_TIMEOUT  = 1200,
  parameter int STABLE_CYCLES = 120,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_resetb,
  output logic       sys_reset_n,
  output logic       running,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL   = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_STABLE_WAIT = 3'd2,
    S_RUN         = 3'd3,
    S_FAULT       = 3'd4
  } state_t;

  // Terminal counter values: the counter starts at 0 on state entry, so the
  // last cycle of an N-cycle window is N-1.
  localparam logic [15:0] RESET_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX    = 2'(MAX_RETRIES);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        lock_meta, lock_sync;
  logic        restart;
  logic        retry_path;
  logic [1:0]  retry_nxt;
  logic [7:0]  loss_nxt;
  logic        pll_resetb_nxt, sys_reset_n_nxt, running_nxt, fault_nxt;

  // Two-flop synchronizer; lock_meta is the only flop that may go metastable.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_RESET_PLL;
      cnt             <= 16'd0;
      pll_resetb      <= 1'b0;
      sys_reset_n     <= 1'b0;
      running         <= 1'b0;
      fault           <= 1'b0;
      retry_count     <= 2'd0;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      pll_resetb      <= pll_resetb_nxt;
      sys_reset_n     <= sys_reset_n_nxt;
      running         <= running_nxt;
      fault           <= fault_nxt;
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    retry_path = 1'b0;
    retry_nxt  = retry_count;
    loss_nxt   = lock_loss_count;

    case (state)
      S_RESET_PLL: begin
        if (relock_req) begin
          restart   = 1'b1;
          retry_nxt = 2'd0;
        end else if (cnt == RESET_LAST) begin
          state_nxt = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end else if (lock_sync) begin
          state_nxt = S_STABLE_WAIT;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_path = 1'b1;
        end
      end
      S_STABLE_WAIT: begin
        // Any low sample aborts, so reaching STABLE_LAST means the lock was
        // continuously high for STABLE_CYCLES cycles.
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end else if (!lock_sync) begin
          retry_path = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Lock loss wins over a coincident relock request so it gets counted.
        if (!lock_sync) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
          if (lock_loss_count != 8'hFF) begin
            loss_nxt = lock_loss_count + 8'd1;
          end
        end else if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 2'd0;
        end
      end
      default: begin
        state_nxt = S_RESET_PLL;
        retry_nxt = 2'd0;
      end
    endcase

    if (retry_path) begin
      if (retry_count == RETRY_MAX) begin
        state_nxt = S_FAULT;
      end else begin
        state_nxt = S_RESET_PLL;
        retry_nxt = retry_count + 2'd1;
      end
    end

    // Cleared on any state change or restart; otherwise counts and parks at
    // all-ones in the unbounded states (RUN, FAULT).
    if ((state_nxt != state) || restart) begin
      cnt_nxt = 16'd0;
    end else if (cnt != 16'hFFFF) begin
      cnt_nxt = cnt + 16'd1;
    end else begin
      cnt_nxt = cnt;
    end

    // Outputs are decoded from the next state so they register with it.
    pll_resetb_nxt  = (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE_WAIT) ||
                      (state_nxt == S_RUN);
    sys_reset_n_nxt = (state_nxt == S_RUN);
    running_nxt     = (state_nxt == S_RUN);
    fault_nxt       = (state_nxt == S_FAULT);
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the iCE40 PLL that derives the 96 MHz system clock from the 12 MHz reference. It holds the PLL in reset, waits for a qualified lock, and releases the system reset only after lock has been stable. It also detects lock loss, re-acquires with bounded retries, and reports a fault. It runs entirely in the 12 MHz reference domain, so it never depends on the clock it supervises.

## Interface
- RESET_CYCLES, 12: cycles `pll_resetb` is held low per attempt (1 µs).
- LOCK_TIMEOUT, 1200: cycles allowed for lock per attempt (100 µs).
- STABLE_CYCLES, 120: consecutive locked cycles required before release (10 µs).
- MAX_RETRIES, 3: re-attempts after the first before FAULT.
- `clock_in`  in  1  12 MHz reference clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL LOCK output; asynchronous to `clock_in`.
- `relock_req`  in  1  single-cycle request to re-sequence the PLL.
- `pll_resetb`  out  1  drives PLL RESETB; active-low.
- `sys_reset_n`  out  1  system reset; active-low. The 96 MHz consumers re-synchronize its deassertion.
- `running`  out  1  high in RUN.
- `fault`  out  1  high in FAULT.
- `retry_count`  out  2  retries used in the current acquisition.
- `lock_loss_count`  out  8  lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to produce `lock_sync`. It is never used raw.
- One cycle counter, 16 bits, cleared on every state change.
- All outputs are registered and change on the same edge as the state.
- States:
  - **RESET_PLL**: `pll_resetb`=0, `sys_reset_n`=0. After RESET_CYCLES cycles, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_resetb`=1. If `lock_sync`=1, go to STABLE_WAIT. If the counter reaches LOCK_TIMEOUT-1 without lock, take the retry path.
  - **STABLE_WAIT**: `pll_resetb`=1. After STABLE_CYCLES consecutive cycles of `lock_sync`=1, go to RUN. If `lock_sync`=0, take the retry path.
  - **RUN**: `sys_reset_n`=1, `running`=1.
    - `lock_sync`=0: `lock_loss_count`+1 (saturating), `retry_count`←0, go to RESET_PLL.
    - `relock_req`=1: `retry_count`←0, go to RESET_PLL; no loss is counted.
  - **FAULT**: `pll_resetb`=0, `sys_reset_n`=0, `fault`=1. Exit only via `relock_req` (`retry_count`←0, go to RESET_PLL) or `reset_n`.
- Retry path:
  - If `retry_count`==MAX_RETRIES, go to FAULT.
  - Otherwise `retry_count`+1 and go to RESET_PLL.
- `relock_req` in RESET_PLL, WAIT_LOCK or STABLE_WAIT: restart at RESET_PLL with `retry_count`←0.
- Simultaneous lock loss and `relock_req` in RUN are handled as a lock loss.
- `retry_count` holds its value through RUN, so it stays observable.

## Timing
- Reset values:
  - State RESET_PLL, counter 0.
  - `pll_resetb`=0, `sys_reset_n`=0, `running`=0, `fault`=0.
  - `retry_count`=0, `lock_loss_count`=0, synchronizer flops 0.
- Asserting `reset_n` mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- `pll_resetb` rises on the RESET_CYCLES-th rising edge after `reset_n` deasserts.
- `sys_reset_n` rises STABLE_CYCLES+3 edges after the first edge that samples `pll_locked`=1 in WAIT_LOCK: 2 cycles of synchronizer, 1 cycle for the state change, then STABLE_CYCLES.
- Lock loss in RUN: `sys_reset_n` falls 3 edges after the first edge sampling `pll_locked`=0, and `pll_resetb` falls on the same edge.
- Each failed attempt lasts RESET_CYCLES+LOCK_TIMEOUT cycles.

## Test plan
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Normal acquisition**: release reset; raise `pll_locked` 6 cycles after `pll_resetb` rises → `pll_resetb` rises at edge 4, `sys_reset_n` and `running` rise 11 edges after `pll_locked` is first sampled, `retry_count`=0.
- **Never locks**: keep `pll_locked`=0 → `retry_count` steps 1 then 2, `fault`=1 after 72 edges, `pll_resetb`=0, `sys_reset_n` stays 0.
- **Dropout during qualification**: drop `pll_locked` for 1 cycle at stable count 5, then hold it high → `retry_count`=1, full RESET_PLL re-entered, RUN reached afterwards.
- **Lock loss in RUN**: drop `pll_locked` → `sys_reset_n`=0 within 3 edges, `lock_loss_count`=1, re-acquisition completes with `retry_count`=0. Repeat 300 times → `lock_loss_count`=255.
- **Recovery from FAULT**: pulse `relock_req` in FAULT with `pll_locked`=1 → `fault`=0 next edge, `retry_count`=0, RUN reached after 4+1+8+1 edges.
- **Reset mid-RUN**: assert `reset_n` asynchronously between edges → all outputs at reset values before the next edge, `lock_loss_count`=0.
